ifetch_unit: RTL and testbench

- Instruction fetch stage of the out-of-order RV32I core; the producer side of the fetch→decode interface.
- Requests instruction words from the memory controller and presents one instruction at a time to the decoder as valid/pc/ins/predicted-taken.
- Predicts JAL and conditional branches with a 2-bit BHT; stalls on JALR until the decoder returns the target; redirects on a ROB clear.

---
 rtl/ifetch_unit_if.sv | 45 ++++
 rtl/ifetch_unit.sv | 157 +++++++++++++++
 tb/tb_ifetch_unit.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/ifetch_unit_if.sv
// Fetch-stage bus bundle: memory request/response channel, fetch->decode
// channel, and the ROB/decoder feedback paths (flush, JALR target, BHT update).
interface ifetch_unit_if;
   logic        rdy;
   logic        clear;
   logic [31:0] clear_pc;
   logic        stall;

   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ok;
   logic [31:0] mem_data;

   logic        to_dec_ok;
   logic [31:0] to_dec_pc;
   logic [31:0] to_dec_ins;
   logic        to_dec_jp;

   logic        jalr_ok;
   logic [31:0] jalr_pc;

   logic        bp_upd;
   logic [31:0] bp_upd_pc;
   logic        bp_upd_taken;

   // fetch unit side
   modport master (
      input  rdy, clear, clear_pc, stall,
      output mem_req, mem_addr,
      input  mem_ok, mem_data,
      output to_dec_ok, to_dec_pc, to_dec_ins, to_dec_jp,
      input  jalr_ok, jalr_pc,
      input  bp_upd, bp_upd_pc, bp_upd_taken
   );

   // environment side (memory controller, decoder, ROB)
   modport slave (
      output rdy, clear, clear_pc, stall,
      input  mem_req, mem_addr,
      output mem_ok, mem_data,
      input  to_dec_ok, to_dec_pc, to_dec_ins, to_dec_jp,
      output jalr_ok, jalr_pc,
      output bp_upd, bp_upd_pc, bp_upd_taken
   );
endinterface

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: fetches one word at a time, predecodes JAL and
// conditional branches against a 2-bit BHT, holds JALR until the decoder
// resolves its target, and redirects on a ROB flush.
//
// state    | meaning
// ---------+----------------------------------------------------------
// FETCH    | launch a memory request for pc next cycle
// WAIT_MEM | request outstanding, waiting for mem_ok
// ISSUE    | instruction presented to decoder, waiting to dispatch
// DROP     | flushed while a request was in flight; discard its data
module ifetch_unit #(
   parameter int          BHT_BITS = 8,
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input  logic          clk,
   input  logic          rst,
   ifetch_unit_if.master bus
);

   localparam int          BHT_SIZE  = 1 << BHT_BITS;
   localparam logic [6:0]  OP_JAL    = 7'b1101111;
   localparam logic [6:0]  OP_JALR   = 7'b1100111;
   localparam logic [6:0]  OP_BRANCH = 7'b1100011;

   typedef enum logic [1:0] {FETCH, WAIT_MEM, ISSUE, DROP} state_t;

   state_t      state;
   logic [31:0] pc;
   logic [31:0] npc;
   logic [1:0]  bht [BHT_SIZE];

   logic [6:0]          opcode;
   logic [31:0]         j_imm;
   logic [31:0]         b_imm;
   logic [BHT_BITS-1:0] rd_idx;
   logic [BHT_BITS-1:0] upd_idx;
   logic                pred_jp;
   logic [31:0]         pred_npc;
   logic                issue_jalr;
   logic                unused_upd_pc_bits;

   assign rd_idx  = pc[BHT_BITS+1:2];
   assign upd_idx = bus.bp_upd_pc[BHT_BITS+1:2];
   // only the index bits of the update PC select an entry
   assign unused_upd_pc_bits = ^{bus.bp_upd_pc[31:BHT_BITS+2], bus.bp_upd_pc[1:0]};

   assign issue_jalr = (bus.to_dec_ins[6:0] == OP_JALR);

   // Predecode the returning word: prediction and next PC from immediate.
   always_comb begin
      opcode   = bus.mem_data[6:0];
      j_imm    = {{12{bus.mem_data[31]}}, bus.mem_data[19:12], bus.mem_data[20],
                  bus.mem_data[30:21], 1'b0};
      b_imm    = {{20{bus.mem_data[31]}}, bus.mem_data[7], bus.mem_data[30:25],
                  bus.mem_data[11:8], 1'b0};
      pred_jp  = 1'b0;
      pred_npc = pc + 32'd4;
      case (opcode)
         OP_JAL: begin
            pred_jp  = 1'b1;
            pred_npc = pc + j_imm;
         end
         OP_BRANCH: begin
            // read of the array before any same-cycle update lands
            pred_jp  = bht[rd_idx][1];
            pred_npc = bht[rd_idx][1] ? (pc + b_imm) : (pc + 32'd4);
         end
         default: begin
            pred_jp  = 1'b0;
            pred_npc = pc + 32'd4;
         end
      endcase
   end

   // Branch history table: saturating 2-bit counters trained by the ROB.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < BHT_SIZE; i++) begin
            bht[i] <= 2'b01;
         end
      end else if (bus.rdy && bus.bp_upd) begin
         if (bus.bp_upd_taken) begin
            if (bht[upd_idx] != 2'b11) bht[upd_idx] <= bht[upd_idx] + 2'b01;
         end else begin
            if (bht[upd_idx] != 2'b00) bht[upd_idx] <= bht[upd_idx] - 2'b01;
         end
      end
   end

   // Fetch sequencer with registered memory and decoder outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= FETCH;
         pc             <= RESET_PC;
         npc            <= 32'h0;
         bus.mem_req    <= 1'b0;
         bus.mem_addr   <= 32'h0;
         bus.to_dec_ok  <= 1'b0;
         bus.to_dec_pc  <= 32'h0;
         bus.to_dec_ins <= 32'h0;
         bus.to_dec_jp  <= 1'b0;
      end else if (bus.rdy) begin
         if (bus.clear) begin
            bus.to_dec_ok <= 1'b0;
            bus.mem_req   <= 1'b0;
            pc            <= bus.clear_pc;
            // an in-flight request must still be absorbed before refetching
            if ((state == WAIT_MEM || state == DROP) && !bus.mem_ok) begin
               state <= DROP;
            end else begin
               state <= FETCH;
            end
         end else begin
            case (state)
               FETCH: begin
                  bus.mem_req  <= 1'b1;
                  bus.mem_addr <= pc;
                  state        <= WAIT_MEM;
               end
               WAIT_MEM: begin
                  if (bus.mem_ok) begin
                     bus.mem_req    <= 1'b0;
                     bus.to_dec_ins <= bus.mem_data;
                     bus.to_dec_pc  <= pc;
                     bus.to_dec_jp  <= pred_jp;
                     bus.to_dec_ok  <= 1'b1;
                     npc            <= pred_npc;
                     state          <= ISSUE;
                  end
               end
               ISSUE: begin
                  if (issue_jalr) begin
                     if (!bus.stall && bus.jalr_ok) begin
                        bus.to_dec_ok <= 1'b0;
                        pc            <= bus.jalr_pc;
                        state         <= FETCH;
                     end
                  end else if (!bus.stall) begin
                     bus.to_dec_ok <= 1'b0;
                     pc            <= npc;
                     state         <= FETCH;
                  end
               end
               DROP: begin
                  if (bus.mem_ok) begin
                     state <= FETCH;
                  end
               end
               default: begin
                  state <= FETCH;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: a table of fetch vectors walked as a
// control-flow chain, followed by hand sequences for flush, BHT training,
// rdy freeze and asynchronous reset.
module tb_ifetch_unit;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   ifetch_unit_if bus_if ();

   ifetch_unit #(.BHT_BITS(8), .RESET_PC(32'h0)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       nm;
      logic [31:0] addr;
      logic [31:0] ins;
      int          lat;
      int          hold;
      int          mode;   // 0 stall hold, 1 JALR wait, 2 rdy low
      logic [31:0] jpc;
      bit          jp;
   } vec_t;

   vec_t vecs[8];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic set_vec(input int i, input string nm, input logic [31:0] a,
                          input logic [31:0] ins, input int lat, input int hold,
                          input int mode, input logic [31:0] jpc, input bit jp);
      vecs[i].nm   = nm;
      vecs[i].addr = a;
      vecs[i].ins  = ins;
      vecs[i].lat  = lat;
      vecs[i].hold = hold;
      vecs[i].mode = mode;
      vecs[i].jpc  = jpc;
      vecs[i].jp   = jp;
   endtask

   task automatic wait_req(input string nm, input logic [31:0] a);
      int n;
      n = 0;
      while (!bus_if.mem_req && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk({nm, "_req"}, {31'b0, bus_if.mem_req}, 32'h1);
      chk({nm, "_addr"}, bus_if.mem_addr, a);
   endtask

   task automatic fetch_one(input string nm, input logic [31:0] a, input logic [31:0] ins,
                            input int lat, input int hold, input int mode,
                            input logic [31:0] jpc, input bit ejp, input bit upd_same);
      wait_req(nm, a);
      repeat (lat) @(negedge clk);
      bus_if.mem_ok   = 1'b1;
      bus_if.mem_data = ins;
      bus_if.stall    = (mode == 0 && hold > 0);
      bus_if.jalr_ok  = 1'b0;
      if (upd_same) begin
         bus_if.bp_upd       = 1'b1;
         bus_if.bp_upd_pc    = a;
         bus_if.bp_upd_taken = 1'b1;
      end
      @(negedge clk);
      bus_if.mem_ok   = 1'b0;
      bus_if.mem_data = 32'hBADC0DE5;
      bus_if.bp_upd   = 1'b0;
      chk({nm, "_ok"},  {31'b0, bus_if.to_dec_ok}, 32'h1);
      chk({nm, "_pc"},  bus_if.to_dec_pc, a);
      chk({nm, "_ins"}, bus_if.to_dec_ins, ins);
      chk({nm, "_jp"},  {31'b0, bus_if.to_dec_jp}, {31'b0, ejp});
      chk({nm, "_req_low"}, {31'b0, bus_if.mem_req}, 32'h0);
      for (int k = 0; k < hold; k++) begin
         if (mode == 2) bus_if.rdy = 1'b0;
         @(negedge clk);
         chk({nm, "_hold_ok"},  {31'b0, bus_if.to_dec_ok}, 32'h1);
         chk({nm, "_hold_pc"},  bus_if.to_dec_pc, a);
         chk({nm, "_hold_ins"}, bus_if.to_dec_ins, ins);
         chk({nm, "_hold_req"}, {31'b0, bus_if.mem_req}, 32'h0);
      end
      bus_if.rdy     = 1'b1;
      bus_if.stall   = 1'b0;
      bus_if.jalr_ok = (mode == 1) || (jpc != 32'h0);
      bus_if.jalr_pc = jpc;
      @(negedge clk);
      bus_if.jalr_ok = 1'b0;
      chk({nm, "_disp_ok"},  {31'b0, bus_if.to_dec_ok}, 32'h0);
      chk({nm, "_disp_req"}, {31'b0, bus_if.mem_req}, 32'h0);
   endtask

   task automatic bp_pulse(input logic [31:0] a, input bit taken);
      bus_if.bp_upd       = 1'b1;
      bus_if.bp_upd_pc    = a;
      bus_if.bp_upd_taken = taken;
      @(negedge clk);
      bus_if.bp_upd = 1'b0;
   endtask

   // flush while a request is outstanding, then return the stale word
   task automatic redirect(input string nm, input logic [31:0] cur, input logic [31:0] npc);
      wait_req(nm, cur);
      bus_if.clear    = 1'b1;
      bus_if.clear_pc = npc;
      @(negedge clk);
      bus_if.clear = 1'b0;
      chk({nm, "_clr_req"}, {31'b0, bus_if.mem_req}, 32'h0);
      chk({nm, "_clr_ok"},  {31'b0, bus_if.to_dec_ok}, 32'h0);
      repeat (2) @(negedge clk);
      chk({nm, "_drop_req"}, {31'b0, bus_if.mem_req}, 32'h0);
      bus_if.mem_ok   = 1'b1;
      bus_if.mem_data = 32'h0100006F;
      @(negedge clk);
      bus_if.mem_ok = 1'b0;
      chk({nm, "_stale_ok"}, {31'b0, bus_if.to_dec_ok}, 32'h0);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst                 = 1'b1;
      bus_if.rdy          = 1'b1;
      bus_if.clear        = 1'b0;
      bus_if.clear_pc     = 32'h0;
      bus_if.stall        = 1'b0;
      bus_if.mem_ok       = 1'b0;
      bus_if.mem_data     = 32'h0;
      bus_if.jalr_ok      = 1'b0;
      bus_if.jalr_pc      = 32'h0;
      bus_if.bp_upd       = 1'b0;
      bus_if.bp_upd_pc    = 32'h0;
      bus_if.bp_upd_taken = 1'b0;

      // chain: each vector's addr is the previous one's hand-computed next PC
      set_vec(0, "addi_0",    32'h0,   32'h00000013, 2, 0, 0, 32'h0, 1'b0);
      set_vec(1, "jal_4",     32'h4,   32'h00C0006F, 1, 0, 0, 32'h0, 1'b1);
      set_vec(2, "jal_10",    32'h10,  32'h0100006F, 1, 0, 0, 32'h0, 1'b1);
      set_vec(3, "jal_20",    32'h20,  32'h0200006F, 3, 0, 0, 32'h0, 1'b1);
      set_vec(4, "beq_40",    32'h40,  32'hFE000CE3, 1, 0, 0, 32'h0, 1'b0);
      set_vec(5, "jal_44_st", 32'h44,  32'h03C0006F, 1, 4, 0, 32'h0, 1'b1);
      set_vec(6, "jalr_80",   32'h80,  32'h00008067, 2, 3, 1, 32'h200, 1'b0);
      set_vec(7, "addi_200",  32'h200, 32'h00000013, 1, 0, 0, 32'hDEAD0000, 1'b0);

      repeat (2) @(negedge clk);
      chk("rst_req",  {31'b0, bus_if.mem_req}, 32'h0);
      chk("rst_addr", bus_if.mem_addr, 32'h0);
      chk("rst_ok",   {31'b0, bus_if.to_dec_ok}, 32'h0);
      chk("rst_pc",   bus_if.to_dec_pc, 32'h0);
      chk("rst_ins",  bus_if.to_dec_ins, 32'h0);
      chk("rst_jp",   {31'b0, bus_if.to_dec_jp}, 32'h0);
      rst = 1'b0;

      for (int i = 0; i < 8; i++) begin
         fetch_one(vecs[i].nm, vecs[i].addr, vecs[i].ins, vecs[i].lat, vecs[i].hold,
                   vecs[i].mode, vecs[i].jpc, vecs[i].jp, 1'b0);
      end

      // flush to 0x1000 while 0x204 is outstanding
      redirect("clr_1000", 32'h204, 32'h1000);
      fetch_one("addi_1000", 32'h1000, 32'h00000013, 1, 0, 0, 32'h0, 1'b0, 1'b0);

      // train 0x40 taken three times: 01 -> 10 -> 11 -> 11
      wait_req("pre_train", 32'h1004);
      bp_pulse(32'h40, 1'b1);
      bp_pulse(32'h40, 1'b1);
      bp_pulse(32'h40, 1'b1);
      redirect("to40_a", 32'h1004, 32'h40);
      fetch_one("beq_tk_a", 32'h40, 32'hFE000CE3, 1, 0, 0, 32'h0, 1'b1, 1'b0);
      fetch_one("addi_38a", 32'h38, 32'h00000013, 1, 0, 0, 32'h0, 1'b0, 1'b0);

      // one not-taken: 11 -> 10, still predicted taken
      bp_pulse(32'h40, 1'b0);
      redirect("to40_b", 32'h3C, 32'h40);
      fetch_one("beq_tk_b", 32'h40, 32'hFE000CE3, 1, 0, 0, 32'h0, 1'b1, 1'b0);
      fetch_one("addi_38b", 32'h38, 32'h00000013, 1, 0, 0, 32'h0, 1'b0, 1'b0);

      // second not-taken: 10 -> 01; lookup with same-cycle taken update sees 01
      bp_pulse(32'h40, 1'b0);
      redirect("to40_c", 32'h3C, 32'h40);
      fetch_one("beq_nt_same", 32'h40, 32'hFE000CE3, 1, 0, 0, 32'h0, 1'b0, 1'b1);

      // the same-cycle update left 10; also freeze with rdy low in ISSUE
      redirect("to40_d", 32'h44, 32'h40);
      fetch_one("beq_rdy", 32'h40, 32'hFE000CE3, 1, 3, 2, 32'h0, 1'b1, 1'b0);

      // asynchronous reset while waiting on memory
      wait_req("pre_rst", 32'h38);
      #2 rst = 1'b1;
      #1;
      chk("arst_req",  {31'b0, bus_if.mem_req}, 32'h0);
      chk("arst_addr", bus_if.mem_addr, 32'h0);
      chk("arst_ok",   {31'b0, bus_if.to_dec_ok}, 32'h0);
      chk("arst_pc",   bus_if.to_dec_pc, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      fetch_one("addi_rst", 32'h0, 32'h00000013, 1, 0, 0, 32'h0, 1'b0, 1'b0);

      // BHT back to 01 after reset
      redirect("to40_e", 32'h4, 32'h40);
      fetch_one("beq_post_rst", 32'h40, 32'hFE000CE3, 1, 0, 0, 32'h0, 1'b0, 1'b0);
      wait_req("final", 32'h44);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
